fetch_pc_nested_irq: RTL and testbench

- Parametrised next-generation instruction-fetch PC unit.
- Owns the PC register and drives the instruction-memory address.
- Selects the next PC among sequential, predicted-branch, misprediction-undo, register-jump, interrupt-vector and interrupt-return sources.
- Replaces the single saved interrupt PC with a prioritised, nestable return stack, so higher-priority interrupts can pre-empt lower ones and back-to-back interrupts tail-chain.

---
 rtl/fetch_pc_nested_irq.sv | 173 +++++++++++++++++
 tb/tb_fetch_pc_nested_irq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_nested_irq.sv
// fetch_pc_nested_irq
// Instruction-fetch PC unit with a prioritised, nestable interrupt return stack.
// It holds the PC register and drives the fetch address combinationally. The
// next PC comes from one of six sources: sequential, predicted branch,
// misprediction undo, register jump, interrupt vector or interrupt return.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           hold the PC; blocks interrupt take and return
//   irq_req         level interrupt requests; bit 0 has the highest priority
//   irq_enable      global interrupt enable
//   branch_predict  redirect to branch_pc
//   branch_undo     misprediction; redirect to pc_not_taken
//   pcr_take        register jump to pcr
//   reti            return from interrupt
//   mem_addr        next PC and fetch address (combinational)
//   pc_plus_4       current PC + 4, wrapping
//   interrupt       interrupt taken this cycle
//   irq_id          id of the taken interrupt, else the active level (0 if none)
//   nest_level      return-stack occupancy
//   stack_full      occupancy equals STACK_DEPTH
//   stack_err       sticky flag, set by reti on an empty stack
//   flush           pipeline flush request
module fetch_pc_nested_irq #(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_IRQ     = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] VEC_BASE    = 'h100,
  parameter int                VEC_STRIDE  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [NUM_IRQ-1:0]               irq_req,
  input  logic                             irq_enable,
  input  logic                             branch_predict,
  input  logic [ADDR_W-1:0]                branch_pc,
  input  logic                             branch_undo,
  input  logic [ADDR_W-1:0]                pc_not_taken,
  input  logic                             pcr_take,
  input  logic [ADDR_W-1:0]                pcr,
  input  logic                             reti,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [ADDR_W-1:0]                pc_plus_4,
  output logic                             interrupt,
  output logic [$clog2(NUM_IRQ)-1:0]       irq_id,
  output logic [$clog2(STACK_DEPTH+1)-1:0] nest_level,
  output logic                             stack_full,
  output logic                             stack_err,
  output logic                             flush
);

  localparam int ID_W   = $clog2(NUM_IRQ);
  localparam int PRIO_W = $clog2(NUM_IRQ + 1);
  localparam int LVL_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  // Priority value one past the lowest real level means "no interrupt active".
  localparam logic [PRIO_W-1:0] PRIO_NONE = PRIO_W'(NUM_IRQ);

  function automatic logic [ADDR_W-1:0] vec_addr(input logic [PRIO_W-1:0] id);
    return VEC_BASE + ADDR_W'(id) * ADDR_W'(VEC_STRIDE);
  endfunction

  logic [ADDR_W-1:0] pc_p0;
  logic [LVL_W-1:0]  occ_p0;
  logic [PRIO_W-1:0] prio_p0;
  logic              err_p0;
  logic [ADDR_W-1:0] stk_addr [STACK_DEPTH];
  logic [PRIO_W-1:0] stk_prio [STACK_DEPTH];

  logic [ADDR_W-1:0] nb;
  logic              pend_vld;
  logic [PRIO_W-1:0] pend_id;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic [ADDR_W-1:0] top_addr;
  logic [PRIO_W-1:0] top_prio;
  logic              has_top;
  logic              ret_ok;
  logic              chain;
  logic [PRIO_W-1:0] elig_prio;
  logic              take;
  logic              pop;

  // ---- stage 0: next-PC selection and interrupt decision ----
  always_comb begin
    pend_vld = 1'b0;
    pend_id  = '0;
    // Scan from the top index down so the lowest set bit wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        pend_vld = 1'b1;
        pend_id  = PRIO_W'(i);
      end
    end
  end

  always_comb begin
    pc_plus_4 = pc_p0 + ADDR_W'(4);

    if (branch_undo)         nb = pc_not_taken;
    else if (pcr_take)       nb = pcr;
    else if (stall)          nb = pc_p0;
    else if (branch_predict) nb = branch_pc;
    else                     nb = pc_plus_4;

    has_top  = (occ_p0 != '0);
    top_idx  = IDX_W'(occ_p0 - LVL_W'(1));
    push_idx = IDX_W'(occ_p0);
    top_addr = stk_addr[top_idx];
    top_prio = stk_prio[top_idx];

    ret_ok   = reti & ~stall & ~branch_undo;
    // A return in the same cycle as a take drops to the popped level first,
    // so eligibility is judged against that level rather than the current one.
    chain     = ret_ok & has_top;
    elig_prio = chain ? top_prio : prio_p0;

    take = ~rst & irq_enable & ~stall & ~branch_undo & pend_vld &
           (pend_id < elig_prio) & (~stack_full | reti);
    pop  = ~rst & ret_ok & ~take;

    if (rst)                  mem_addr = RESET_PC;
    else if (take)            mem_addr = vec_addr(pend_id);
    else if (pop && has_top)  mem_addr = top_addr;
    else                      mem_addr = nb;

    interrupt = take;
    flush     = ~rst & (take | pop | branch_undo | pcr_take);

    if (take)                   irq_id = ID_W'(pend_id);
    else if (prio_p0 < PRIO_NONE) irq_id = ID_W'(prio_p0);
    else                        irq_id = '0;
  end

  assign nest_level = occ_p0;
  assign stack_full = (occ_p0 == LVL_W'(STACK_DEPTH));
  assign stack_err  = err_p0;

  // ---- stage 0 -> 1: PC, priority and stack-control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0   <= RESET_PC;
      occ_p0  <= '0;
      prio_p0 <= PRIO_NONE;
      err_p0  <= 1'b0;
    end else begin
      pc_p0 <= mem_addr;
      if (take) begin
        prio_p0 <= pend_id;
        // A tail-chain reuses the popped entry as-is, so occupancy stays put.
        if (!chain) occ_p0 <= occ_p0 + LVL_W'(1);
      end else if (pop) begin
        if (has_top) begin
          prio_p0 <= top_prio;
          occ_p0  <= occ_p0 - LVL_W'(1);
        end else begin
          err_p0 <= 1'b1;
        end
      end
    end
  end

  // Stack contents are plain data; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (take && !chain) begin
      stk_addr[push_idx] <= nb;
      stk_prio[push_idx] <= prio_p0;
    end
  end

endmodule

// File: tb/tb_fetch_pc_nested_irq.sv
module tb_fetch_pc_nested_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [7:0]  irq_req;
  logic        irq_enable;
  logic        branch_predict;
  logic [31:0] branch_pc;
  logic        branch_undo;
  logic [31:0] pc_not_taken;
  logic        pcr_take;
  logic [31:0] pcr;
  logic        reti;
  logic [31:0] mem_addr;
  logic [31:0] pc_plus_4;
  logic        interrupt;
  logic [2:0]  irq_id;
  logic [2:0]  nest_level;
  logic        stack_full;
  logic        stack_err;
  logic        flush;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_pc_nested_irq #(
    .ADDR_W(32), .NUM_IRQ(8), .STACK_DEPTH(4),
    .RESET_PC(32'h0), .VEC_BASE(32'h100), .VEC_STRIDE(16)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .irq_req(irq_req),
    .irq_enable(irq_enable), .branch_predict(branch_predict),
    .branch_pc(branch_pc), .branch_undo(branch_undo),
    .pc_not_taken(pc_not_taken), .pcr_take(pcr_take), .pcr(pcr),
    .reti(reti), .mem_addr(mem_addr), .pc_plus_4(pc_plus_4),
    .interrupt(interrupt), .irq_id(irq_id), .nest_level(nest_level),
    .stack_full(stack_full), .stack_err(stack_err), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic [31:0] e_mem,
                          input logic e_int, input logic e_flush);
    chk({tag, ".mem_addr"}, mem_addr, e_mem);
    chk({tag, ".interrupt"}, 32'(interrupt), 32'(e_int));
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; irq_req = '0; irq_enable = 1'b0;
    branch_predict = 1'b0; branch_pc = '0; branch_undo = 1'b0;
    pc_not_taken = '0; pcr_take = 1'b0; pcr = '0; reti = 1'b0;

    // reset state
    #1;
    chk_comb("rst", 32'h0, 1'b0, 1'b0);
    tick;
    chk("rst.nest", 32'(nest_level), 32'd0);
    chk("rst.err", 32'(stack_err), 32'd0);
    chk("rst.id", 32'(irq_id), 32'd0);
    chk("rst.full", 32'(stack_full), 32'd0);
    chk("rst.pc4", pc_plus_4, 32'h4);

    // free run
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("run.mem", mem_addr, 32'(i * 4));
      tick;
    end
    rst = 1'b1;
    #1 chk_comb("rerst", 32'h0, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    #1 chk("rerst.pc4", pc_plus_4, 32'h4);

    // register jump to 0x40, then take irq 2
    pcr_take = 1'b1; pcr = 32'h40;
    #1 chk_comb("pcr", 32'h40, 1'b0, 1'b1);
    tick;
    pcr_take = 1'b0; irq_enable = 1'b1; irq_req = 8'h04;
    #1 chk_comb("take2", 32'h120, 1'b1, 1'b1);
    chk("take2.id", 32'(irq_id), 32'd2);
    tick;
    chk("take2.nest", 32'(nest_level), 32'd1);
    chk("take2.active", 32'(irq_id), 32'd2);

    // equal and lower priority are not taken
    #1 chk_comb("eq2", 32'h124, 1'b0, 1'b0);
    tick;
    irq_req = 8'h08;
    #1 chk_comb("low3", 32'h128, 1'b0, 1'b0);
    tick;

    // nest irq 0 inside irq 2
    irq_req = 8'h01;
    #1 chk_comb("nest0", 32'h100, 1'b1, 1'b1);
    chk("nest0.id", 32'(irq_id), 32'd0);
    tick;
    chk("nest0.nest", 32'(nest_level), 32'd2);
    irq_req = 8'h00; reti = 1'b1;
    #1 chk_comb("ret1", 32'h12C, 1'b0, 1'b1);
    tick;
    chk("ret1.nest", 32'(nest_level), 32'd1);
    chk("ret1.id", 32'(irq_id), 32'd2);
    #1 chk("ret2.mem", mem_addr, 32'h44);
    tick;
    reti = 1'b0;
    chk("ret2.nest", 32'(nest_level), 32'd0);
    chk("ret2.id", 32'(irq_id), 32'd0);

    // tail-chain: reti with irq 1 pending at depth 1
    pcr_take = 1'b1; pcr = 32'h40;
    #1;
    tick;
    pcr_take = 1'b0; irq_req = 8'h04;
    #1 chk("tc.take.mem", mem_addr, 32'h120);
    tick;
    irq_req = 8'h02; reti = 1'b1;
    #1 chk_comb("tc", 32'h110, 1'b1, 1'b1);
    chk("tc.id", 32'(irq_id), 32'd1);
    tick;
    chk("tc.nest", 32'(nest_level), 32'd1);
    chk("tc.active", 32'(irq_id), 32'd1);
    irq_req = 8'h00;
    #1 chk("tc.ret.mem", mem_addr, 32'h44);
    tick;
    reti = 1'b0;
    chk("tc.ret.nest", 32'(nest_level), 32'd0);

    // fill the stack with escalating priorities 4,3,2,1
    for (int i = 0; i < 4; i++) begin
      irq_req = 8'h10 >> i;
      #1;
      chk("fill.mem", mem_addr, 32'h140 - 32'(16 * i));
      chk("fill.int", 32'(interrupt), 32'd1);
      tick;
      chk("fill.nest", 32'(nest_level), 32'(i + 1));
    end
    chk("full", 32'(stack_full), 32'd1);
    irq_req = 8'h01;
    #1 chk_comb("defer", 32'h114, 1'b0, 1'b0);
    tick;
    chk("defer.nest", 32'(nest_level), 32'd4);

    // reti with the deferred request chains into it at full depth
    reti = 1'b1;
    #1 chk_comb("fulltc", 32'h100, 1'b1, 1'b1);
    tick;
    chk("fulltc.nest", 32'(nest_level), 32'd4);
    chk("fulltc.id", 32'(irq_id), 32'd0);
    irq_req = 8'h00;
    #1 chk("unw1.mem", mem_addr, 32'h124);
    tick;
    chk("unw1.nest", 32'(nest_level), 32'd3);
    chk("unw1.id", 32'(irq_id), 32'd2);
    #1 chk("unw2.mem", mem_addr, 32'h134);
    tick;
    #1 chk("unw3.mem", mem_addr, 32'h144);
    tick;
    #1 chk("unw4.mem", mem_addr, 32'h48);
    tick;
    chk("unw4.nest", 32'(nest_level), 32'd0);
    chk("unw4.err", 32'(stack_err), 32'd0);

    // reti on empty stack
    #1 chk("empty.mem", mem_addr, 32'h4C);
    chk("empty.int", 32'(interrupt), 32'd0);
    tick;
    chk("empty.err", 32'(stack_err), 32'd1);
    chk("empty.nest", 32'(nest_level), 32'd0);
    reti = 1'b0;

    // stall with irq pending
    stall = 1'b1; irq_req = 8'h04;
    #1 chk_comb("stall", 32'h4C, 1'b0, 1'b0);
    tick;
    chk("stall.pc4", pc_plus_4, 32'h50);

    // branch_undo and irq together: undo wins, irq next cycle
    stall = 1'b0; branch_undo = 1'b1; pc_not_taken = 32'h200;
    #1 chk_comb("undo", 32'h200, 1'b0, 1'b1);
    tick;
    branch_undo = 1'b0;
    #1 chk_comb("undo.next", 32'h120, 1'b1, 1'b1);
    tick;
    chk("undo.nest", 32'(nest_level), 32'd1);

    // predicted branch inside a handler
    irq_req = 8'h00; branch_predict = 1'b1; branch_pc = 32'h300;
    #1 chk_comb("bp", 32'h300, 1'b0, 1'b0);
    tick;
    branch_predict = 1'b0;
    chk("bp.err_sticky", 32'(stack_err), 32'd1);

    // reset mid-nest
    rst = 1'b1;
    #1 chk_comb("midrst", 32'h0, 1'b0, 1'b0);
    tick;
    chk("midrst.nest", 32'(nest_level), 32'd0);
    chk("midrst.err", 32'(stack_err), 32'd0);
    chk("midrst.id", 32'(irq_id), 32'd0);
    chk("midrst.pc4", pc_plus_4, 32'h4);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
